// File: rtl/sc_fifo_rr_sched_pkg.sv
// Shared types for the round-robin FIFO read scheduler.
package sc_fifo_sched_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/sc_fifo_rr_sched_if.sv
// FIFO-bank side and consumer side of the round-robin read scheduler.
interface sc_fifo_rr_sched_if #(
  parameter int FIFO_CNT   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = $clog2(FIFO_CNT)
);

  logic [FIFO_CNT-1:0]            fifo_empty_i;
  logic [FIFO_CNT*DATA_WIDTH-1:0] fifo_data_i;
  logic [FIFO_CNT-1:0]            fifo_rd_o;
  logic [DATA_WIDTH-1:0]          data_o;
  logic [SEL_WIDTH-1:0]           sel_o;
  logic                           valid_o;
  logic                           ready_i;

  modport master (
    input  fifo_empty_i, fifo_data_i, ready_i,
    output fifo_rd_o, data_o, sel_o, valid_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, ready_i,
    input  fifo_rd_o, data_o, sel_o, valid_o
  );

endinterface

// File: rtl/sc_fifo_rr_sched_rr_pick.sv
// Combinational round-robin search: first set bit of req at or after start, wrapping.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] k;

  // Scan from the far end back toward start so the nearest request wins the last write.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = W'((int'(start) + i) % N);
      if (req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/sc_fifo_rr_sched.sv
// Round-robin read scheduler draining a bank of show-ahead FIFOs into one
// registered valid/ready stream, with at most BURST_LEN words per grant.
module sc_fifo_rr_sched
  import sc_fifo_sched_pkg::*;
#(
  parameter int FIFO_CNT   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int SEL_WIDTH  = $clog2(FIFO_CNT)
) (
  input logic                clk_i,
  input logic                rst_i,
  sc_fifo_rr_sched_if.master bus
);

  localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);

  sched_state_t         state_q, state_d;
  logic [SEL_WIDTH-1:0] grant_q, grant_d;
  logic [SEL_WIDTH-1:0] last_q, last_d;
  logic [CNT_WIDTH-1:0] burst_q, burst_d;
  logic [SEL_WIDTH-1:0] start_ptr;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_found;
  logic                 grant_empty;
  logic                 burst_done;
  logic                 pop;

  assign start_ptr   = (last_q == SEL_WIDTH'(FIFO_CNT - 1)) ? '0 : last_q + SEL_WIDTH'(1);
  assign grant_empty = bus.fifo_empty_i[grant_q];
  assign burst_done  = (burst_q == CNT_WIDTH'(BURST_LEN - 1));

  // Reset gates the pop so a FIFO is never drained while the scheduler is clearing.
  assign pop = !rst_i && (state_q == GRANT) && !grant_empty && (!bus.valid_o || bus.ready_i);
  assign bus.fifo_rd_o = pop ? (FIFO_CNT'(1) << grant_q) : '0;

  rr_pick #(
    .N (FIFO_CNT),
    .W (SEL_WIDTH)
  ) u_pick (
    .req   (~bus.fifo_empty_i),
    .start (start_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (pop) begin
          burst_d = burst_q + CNT_WIDTH'(1);
        end
        if ((pop && burst_done) || grant_empty) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop refills the output register even while the old word is being accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= SEL_WIDTH'(FIFO_CNT - 1);
      burst_q     <= '0;
      bus.data_o  <= '0;
      bus.sel_o   <= '0;
      bus.valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      if (pop) begin
        bus.data_o  <= bus.fifo_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
        bus.sel_o   <= grant_q;
        bus.valid_o <= 1'b1;
      end else if (bus.ready_i) begin
        bus.valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sc_fifo_rr_sched.sv
// Self-checking bench: behavioural show-ahead FIFOs feed the scheduler and a
// per-source scoreboard checks every accepted word.
module tb_sc_fifo_rr_sched;

  localparam int FIFO_CNT   = 4;
  localparam int DATA_WIDTH = 8;
  localparam int BURST_LEN  = 4;
  localparam int SEL_WIDTH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_fifo_rr_sched_if #(
    .FIFO_CNT   (FIFO_CNT),
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) bus ();

  sc_fifo_rr_sched #(
    .FIFO_CNT   (FIFO_CNT),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .SEL_WIDTH  (SEL_WIDTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [DATA_WIDTH-1:0] fq    [FIFO_CNT][$];
  logic [DATA_WIDTH-1:0] exp_q [FIFO_CNT][$];
  int acc_sel[$];
  int acc_cyc[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int run_len = 0;
  bit mon_en = 1'b0;
  bit chk_burst = 1'b0;
  logic [FIFO_CNT-1:0]   rd_pend = '0;
  logic [FIFO_CNT-1:0]   mon_rd;
  logic                  mon_valid, mon_ready, prev_stall;
  logic [DATA_WIDTH-1:0] mon_data, prev_data;
  logic [SEL_WIDTH-1:0]  mon_sel, prev_sel;
  logic [DATA_WIDTH-1:0] next_word = 8'h10;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic void refresh();
    for (int i = 0; i < FIFO_CNT; i++) begin
      bus.fifo_empty_i[i] = (fq[i].size() == 0);
      bus.fifo_data_i[i*DATA_WIDTH +: DATA_WIDTH] = (fq[i].size() == 0) ? '0 : fq[i][0];
    end
  endfunction

  // Pushing a word into a source FIFO also records it as expected output of that source.
  task automatic applyStimulus(input int src, input int n, input bit rnd);
    logic [DATA_WIDTH-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DATA_WIDTH'($urandom) : next_word;
      next_word = next_word + 8'd1;
      fq[src].push_back(w);
      exp_q[src].push_back(w);
    end
    refresh();
  endtask

  task automatic monitor();
    cyc++;
    mon_valid = bus.valid_o;
    mon_ready = bus.ready_i;
    mon_rd    = bus.fifo_rd_o;
    mon_data  = bus.data_o;
    mon_sel   = bus.sel_o;
    rd_pend   = bus.fifo_rd_o;
    if (!mon_en) begin
      prev_stall = 1'b0;
      run_len = 0;
      return;
    end
    if (mon_rd != '0) begin
      checkOutput("rd_onehot", 32'($onehot(mon_rd)), 32'd1);
      checkOutput("rd_to_empty", 32'(mon_rd & bus.fifo_empty_i), 32'd0);
    end
    if (prev_stall) begin
      checkOutput("hold_valid", 32'(mon_valid), 32'd1);
      checkOutput("hold_data", 32'(mon_data), 32'(prev_data));
      checkOutput("hold_sel", 32'(mon_sel), 32'(prev_sel));
    end
    if (mon_valid && !mon_ready) checkOutput("stall_rd", 32'(mon_rd), 32'd0);
    // Pops between two unstalled pop-free cycles form one burst.
    if (mon_rd != '0) begin
      run_len++;
    end else if (!(mon_valid && !mon_ready)) begin
      if (chk_burst && run_len > 0 && (~bus.fifo_empty_i) != '0)
        checkOutput("burst_len", 32'(run_len), 32'(BURST_LEN));
      run_len = 0;
    end
    if (mon_valid && mon_ready) begin
      if (exp_q[mon_sel].size() == 0) checkOutput("sb_extra", 32'(exp_q[mon_sel].size()), 32'd1);
      else checkOutput("sb_data", 32'(mon_data), 32'(exp_q[mon_sel].pop_front()));
      acc_sel.push_back(int'(mon_sel));
      acc_cyc.push_back(cyc);
    end
    prev_stall = mon_valid && !mon_ready;
    prev_data  = mon_data;
    prev_sel   = mon_sel;
  endtask

  task automatic popFifos();
    for (int i = 0; i < FIFO_CNT; i++)
      if (rd_pend[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    refresh();
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    popFifos();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    bus.ready_i = 1'b0;
    mon_en = 1'b0;
    chk_burst = 1'b0;
    for (int i = 0; i < FIFO_CNT; i++) begin
      fq[i].delete();
      exp_q[i].delete();
    end
    acc_sel.delete();
    acc_cyc.delete();
    refresh();
    repeat (2) step();
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic waitFirstValid(output int k);
    k = 0;
    step();
    while (!mon_valid && k < 20) begin
      k++;
      step();
    end
  endtask

  task automatic waitAccepts(input string tag, input int n, input int budget);
    int b = 0;
    while (acc_sel.size() < n && b < budget) begin
      step();
      b++;
    end
    checkOutput(tag, 32'(acc_sel.size() >= n), 32'd1);
  endtask

  task automatic checkDrained(input string tag, input int budget);
    int left;
    int b = 0;
    left = 1;
    while (left != 0 && b < budget) begin
      step();
      b++;
      left = 0;
      for (int i = 0; i < FIFO_CNT; i++) left += exp_q[i].size();
    end
    checkOutput(tag, 32'(left), 32'd0);
  endtask

  initial begin
    int k;
    logic [DATA_WIDTH-1:0] held;
    bus.ready_i = 1'b0;
    refresh();

    // Reset values
    applyReset();
    step();
    checkOutput("rst_valid", 32'(mon_valid), 32'd0);
    checkOutput("rst_rd", 32'(mon_rd), 32'd0);
    checkOutput("rst_data", 32'(mon_data), 32'd0);
    checkOutput("rst_sel", 32'(mon_sel), 32'd0);

    // Single source, latency, then a wrapped search to FIFO 1
    bus.ready_i = 1'b1;
    applyStimulus(2, 3, 1'b0);
    waitFirstValid(k);
    checkOutput("single_latency", 32'(k), 32'd2);
    waitAccepts("single_accepts", 3, 20);
    for (int i = 0; i < acc_sel.size(); i++) checkOutput("single_sel", 32'(acc_sel[i]), 32'd2);
    repeat (3) step();
    applyStimulus(1, 1, 1'b0);
    waitFirstValid(k);
    checkOutput("wrap_latency", 32'(k), 32'd2);
    checkOutput("wrap_sel", 32'(mon_sel), 32'd1);
    checkDrained("single_drain", 20);

    // Fairness across four full sources
    applyReset();
    bus.ready_i = 1'b1;
    chk_burst = 1'b1;
    for (int s = 0; s < FIFO_CNT; s++) applyStimulus(s, 8, 1'b0);
    waitAccepts("fair_accepts", 32, 120);
    for (int i = 0; i < acc_sel.size() && i < 32; i++) begin
      checkOutput("fair_sel", 32'(acc_sel[i]), 32'((i / BURST_LEN) % FIFO_CNT));
      if (i > 0) checkOutput("fair_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), (i % BURST_LEN == 0) ? 32'd2 : 32'd1);
    end
    checkDrained("fair_drain", 20);

    // Backpressure mid-burst
    applyReset();
    bus.ready_i = 1'b1;
    chk_burst = 1'b1;
    applyStimulus(0, 8, 1'b0);
    waitAccepts("bp_pre", 2, 20);
    bus.ready_i = 1'b0;
    step();
    held = mon_data;
    repeat (4) step();
    checkOutput("bp_held", 32'(mon_data), 32'(held));
    checkOutput("bp_rd", 32'(mon_rd), 32'd0);
    bus.ready_i = 1'b1;
    waitAccepts("bp_accepts", 8, 40);
    checkDrained("bp_drain", 20);
    chk_burst = 1'b0;

    // Reset during the second word of a burst
    applyReset();
    bus.ready_i = 1'b1;
    applyStimulus(2, 4, 1'b0);
    waitFirstValid(k);
    checkOutput("mid_latency", 32'(k), 32'd2);
    rst = 1'b1;
    bus.ready_i = 1'b0;
    mon_en = 1'b0;
    applyStimulus(0, 1, 1'b0);
    step();
    checkOutput("mid_rst_rd", 32'(mon_rd), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    bus.ready_i = 1'b1;
    // The word sitting in the output register is lost with the reset.
    if (exp_q[2].size() > 0) void'(exp_q[2].pop_front());
    step();
    checkOutput("mid_valid", 32'(mon_valid), 32'd0);
    step();
    checkOutput("mid_prio_rd", 32'(mon_rd), 32'd1);
    checkDrained("mid_drain", 30);

    // Random traffic with random ready
    applyReset();
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < FIFO_CNT; s++)
        if ($urandom_range(0, 3) == 0 && fq[s].size() < 16) applyStimulus(s, 1, 1'b1);
      bus.ready_i = ($urandom_range(0, 9) < 7);
      step();
    end
    bus.ready_i = 1'b1;
    checkDrained("rand_drain", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_fifo_rr_sched.md
# sc_fifo_rr_sched

Round-robin read scheduler that drains up to FIFO_CNT `sc_fifo` instances into a single valid/ready output stream. It sits between a bank of per-source `sc_fifo`s and a shared downstream consumer, issuing the `rd_i` pops and registering the selected word. Each source may send at most BURST_LEN words before the grant rotates.

## Interface
Parameters:
- FIFO_CNT, 4: number of source FIFOs; must be at least 2.
- DATA_WIDTH, 8: word width; matches the FIFOs.
- BURST_LEN, 4: maximum words popped per grant; must be at least 1.
- SEL_WIDTH, $clog2( FIFO_CNT ): source index width.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- fifo_empty_i  in  FIFO_CNT  `empty_o` of each FIFO; bit i is FIFO i.
- fifo_data_i  in  FIFO_CNT*DATA_WIDTH  `rd_data_o` of each FIFO, packed; FIFO i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_rd_o  out  FIFO_CNT  pop strobes to `rd_i`; at most one bit is high.
- data_o  out  DATA_WIDTH  registered output word.
- sel_o  out  SEL_WIDTH  source index of data_o.
- valid_o  out  1  data_o/sel_o hold a word.
- ready_i  in  1  consumer accepts the word when valid_o && ready_i.

## Operation
- The FIFOs are show-ahead: fifo_data_i[i] is valid whenever fifo_empty_i[i]=0, and a pop presents the next word one cycle later.
- FSM states are IDLE and GRANT.
- IDLE:
  - Search fifo_empty_i starting at (last+1) mod FIFO_CNT and wrapping; pick the first non-empty FIFO.
  - If one is found, register grant=index, clear burst_cnt and go to GRANT. Otherwise stay in IDLE.
  - IDLE never pops.
- GRANT:
  - pop = !fifo_empty_i[grant] && (!valid_o || ready_i).
  - On pop:
    - fifo_rd_o[grant]=1.
    - data_o <= fifo_data_i[grant], sel_o <= grant, valid_o <= 1.
    - burst_cnt increments.
  - Leave GRANT for IDLE, with last <= grant, when either:
    - pop occurs and burst_cnt == BURST_LEN-1, or
    - fifo_empty_i[grant]=1.
- Output register:
  - valid_o clears on ready_i when no pop occurs in that cycle.
  - While valid_o && !ready_i, data_o and sel_o are held stable.
  - valid_o never depends combinationally on ready_i.
- Guarantees:
  - fifo_rd_o is never asserted to an empty FIFO or to a non-granted FIFO.
  - No word is dropped or duplicated.
- burst_cnt width is $clog2( BURST_LEN+1 ). The last pointer wraps from FIFO_CNT-1 to 0.

## Timing
- Reset values:
  - valid_o=0, fifo_rd_o=0, data_o=0, sel_o=0.
  - State IDLE, last=FIFO_CNT-1, so FIFO 0 has first priority.
- Latency:
  - A FIFO goes non-empty in cycle N while the block is idle.
  - Grant is registered at edge N.
  - Pop occurs in cycle N+1.
  - valid_o=1 from cycle N+2.
- Throughput:
  - One word per cycle within a burst while ready_i=1.
  - One bubble cycle per grant change, spent in IDLE.
- ready_i=0 stalls pops; the grant is kept and burst_cnt is unchanged.
- If the granted FIFO drains mid-burst, the grant is released the cycle fifo_empty_i rises. Burst words are not reserved.
- Reset mid-burst: FSM, pointer and output register clear in the same cycle. A word already popped but not yet accepted is discarded. This is documented behaviour.
- Simultaneous pop and ready_i acceptance: the new word replaces the old one and valid_o stays 1.

## Structure
- Package `sc_fifo_sched_pkg` holds the state enum typedef (IDLE, GRANT).
- Sub-module `rr_pick`: combinational search from a start pointer over a request vector; outputs found and index. Reusable by other arbiters.
- The FIFOs are instantiated outside this block.

## Test plan
- Single source: FIFO 2 holds 3 words, BURST_LEN=4, ready_i=1 -> words arrive in order with sel_o=2. valid_o is first high 2 cycles after the FIFO goes non-empty. The block returns to IDLE when the FIFO empties.
- Fairness: all 4 FIFOs hold 8 words, BURST_LEN=4 -> sel_o sequence is 0×4, 1×4, 2×4, 3×4, 0×4, … with one bubble between groups.
- BURST_LEN=1, FIFOs 1 and 3 non-empty -> sel_o alternates 1, 3, 1, 3.
- Backpressure: ready_i=0 for 5 cycles mid-burst -> data_o/sel_o stable, fifo_rd_o=0, and burst_cnt continues correctly after release.
- Reset mid-burst: assert rst_i in the 2nd word of a burst -> next cycle valid_o=0 and FIFO 0 has priority; no pop is issued during reset.
- Random traffic with random ready_i -> a scoreboard confirms per-source order, no loss or duplication, and no pop to an empty FIFO.
